// File: rtl/inst_constraint_pkg.sv
// Shared types and encodings for the instruction legality monitor.
// Optional MUL support is selected with the INST_CONSTRAINT_MUL_EN macro.
package inst_constraint_pkg;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_ALU_R  = 3'd1,
        CLS_ALU_I  = 3'd2,
        CLS_MEM    = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JUMP   = 3'd5,
        CLS_UPPER  = 3'd6,
        CLS_NOP    = 3'd7
    } inst_class_e;

    localparam int NUM_CLASSES = 8;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_NOP    = 7'b1111111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    function automatic logic reg_ok(input logic [4:0] r, input int limit);
        return int'({27'd0, r}) < limit;
    endfunction

endpackage

// File: rtl/inst_classify.sv
// Combinational single-lane decoder: instruction class plus legality.
// INST_CONSTRAINT_MUL_EN enables MUL/MULH/MULHSU/MULHU as legal ALU_R.
module inst_classify
    import inst_constraint_pkg::*;
#(
    parameter int REG_LIMIT    = 32,
    parameter int MEM_RESTRICT = 0
) (
    input  logic [31:0]  inst,
    output inst_class_e  inst_class,
    output logic         allowed
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       mul_legal;
    logic       mem_ok;
    logic       regs_ok;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

`ifdef INST_CONSTRAINT_MUL_EN
    assign mul_legal = (funct7 == F7_MUL) && !funct3[2];
`else
    assign mul_legal = 1'b0;
`endif

    // QED memory rule: base register x0 and a small positive offset only
    assign mem_ok = (MEM_RESTRICT == 0) || ((rs1 == 5'd0) && (inst[31:30] == 2'b00));

    always_comb begin
        inst_class = CLS_NONE;
        regs_ok    = 1'b1;
        case (opcode)
            OP_R: begin
                if ((funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))) ||
                    mul_legal)
                    inst_class = CLS_ALU_R;
                regs_ok = reg_ok(rd, REG_LIMIT) && reg_ok(rs1, REG_LIMIT) && reg_ok(rs2, REG_LIMIT);
            end
            OP_I: begin
                case (funct3)
                    3'b001:  if (funct7 == F7_BASE) inst_class = CLS_ALU_I;
                    3'b101:  if ((funct7 == F7_BASE) || (funct7 == F7_ALT)) inst_class = CLS_ALU_I;
                    default: inst_class = CLS_ALU_I;
                endcase
                regs_ok = reg_ok(rd, REG_LIMIT) && reg_ok(rs1, REG_LIMIT);
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) inst_class = CLS_MEM;
                regs_ok = reg_ok(rd, REG_LIMIT) && mem_ok;
            end
            OP_STORE: begin
                if (funct3 == 3'b010) inst_class = CLS_MEM;
                regs_ok = reg_ok(rs2, REG_LIMIT) && mem_ok;
            end
            OP_BRANCH: begin
                if ((funct3 != 3'b010) && (funct3 != 3'b011)) inst_class = CLS_BRANCH;
            end
            OP_JAL:  inst_class = CLS_JUMP;
            OP_JALR: if (funct3 == 3'b000) inst_class = CLS_JUMP;
            OP_LUI, OP_AUIPC: inst_class = CLS_UPPER;
            OP_NOP:  inst_class = CLS_NOP;
            default: inst_class = CLS_NONE;
        endcase
    end

    // A register-limit failure keeps the decoded class but clears legality
    assign allowed = (inst_class != CLS_NONE) && regs_ok;

endmodule

// File: rtl/inst_constraint_mon.sv
// Multi-lane instruction legality monitor: registered per-lane results,
// saturating statistics and a sticky first-violation record (INST_CONSTRAINT_MUL_EN).
module inst_constraint_mon
    import inst_constraint_pkg::*;
#(
    parameter int LANES        = 2,
    parameter int REG_LIMIT    = 32,
    parameter int MEM_RESTRICT = 0,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [LANES-1:0]       inst_valid,
    input  logic [32*LANES-1:0]    inst,
    output logic [LANES-1:0]       out_valid,
    output logic [3*LANES-1:0]     out_class,
    output logic [LANES-1:0]       out_allowed,
    output logic                   illegal_seen,
    output logic [31:0]            first_bad_inst,
    output logic [1:0]             first_bad_lane,
    output logic [CNT_W-1:0]       first_bad_cycle,
    output logic [8*CNT_W-1:0]     class_cnt,
    output logic [CNT_W-1:0]       illegal_cnt
);

    inst_class_e lane_class [LANES];
    logic [LANES-1:0] lane_ok;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            inst_classify #(
                .REG_LIMIT    (REG_LIMIT),
                .MEM_RESTRICT (MEM_RESTRICT)
            ) u_classify (
                .inst       (inst[32*gi +: 32]),
                .inst_class (lane_class[gi]),
                .allowed    (lane_ok[gi])
            );
        end
    endgenerate

    logic [LANES-1:0]                       valid_q,   valid_d;
    logic [3*LANES-1:0]                     class_q,   class_d;
    logic [LANES-1:0]                       allowed_q, allowed_d;
    logic                                   seen_q,    seen_d;
    logic [31:0]                            bad_inst_q, bad_inst_d;
    logic [1:0]                             bad_lane_q, bad_lane_d;
    logic [CNT_W-1:0]                       bad_cycle_q, bad_cycle_d;
    logic [CNT_W-1:0]                       cycle_q,   cycle_d;
    logic [NUM_CLASSES-1:0][CNT_W-1:0]      cnt_q,     cnt_d;
    logic [CNT_W-1:0]                       ill_q,     ill_d;

    logic [2:0] cls_inc [NUM_CLASSES];
    logic [2:0] ill_inc;
    logic       found;

    // Increment is at most LANES (<= 4), so one carry bit detects overflow
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-2){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_comb begin
        valid_d     = inst_valid;
        class_d     = '0;
        allowed_d   = '0;
        seen_d      = seen_q;
        bad_inst_d  = bad_inst_q;
        bad_lane_d  = bad_lane_q;
        bad_cycle_d = bad_cycle_q;
        cycle_d     = cycle_q;
        cnt_d       = cnt_q;
        ill_d       = ill_q;
        ill_inc     = '0;
        found       = 1'b0;
        for (int c = 0; c < NUM_CLASSES; c++) cls_inc[c] = '0;

        for (int l = 0; l < LANES; l++) begin
            if (inst_valid[l]) begin
                class_d[3*l +: 3] = lane_class[l];
                allowed_d[l]      = lane_ok[l];
                if (lane_ok[l]) cls_inc[lane_class[l]] = cls_inc[lane_class[l]] + 3'd1;
                else            ill_inc = ill_inc + 3'd1;
            end
        end

        if (clear) begin
            seen_d      = 1'b0;
            bad_inst_d  = '0;
            bad_lane_d  = '0;
            bad_cycle_d = '0;
            cycle_d     = '0;
            cnt_d       = '0;
            ill_d       = '0;
        end else begin
            cycle_d = sat_add(cycle_q, 3'd1);
            ill_d   = sat_add(ill_q, ill_inc);
            for (int c = 0; c < NUM_CLASSES; c++) cnt_d[c] = sat_add(cnt_q[c], cls_inc[c]);
            // Lowest-index illegal lane wins; record is frozen once set
            for (int l = 0; l < LANES; l++) begin
                if (inst_valid[l] && !lane_ok[l] && !seen_q && !found) begin
                    found       = 1'b1;
                    bad_inst_d  = inst[32*l +: 32];
                    bad_lane_d  = 2'(l);
                    bad_cycle_d = cycle_q;
                end
            end
            seen_d = seen_q | found;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= '0;
            class_q     <= '0;
            allowed_q   <= '0;
            seen_q      <= 1'b0;
            bad_inst_q  <= '0;
            bad_lane_q  <= '0;
            bad_cycle_q <= '0;
            cycle_q     <= '0;
            cnt_q       <= '0;
            ill_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            class_q     <= class_d;
            allowed_q   <= allowed_d;
            seen_q      <= seen_d;
            bad_inst_q  <= bad_inst_d;
            bad_lane_q  <= bad_lane_d;
            bad_cycle_q <= bad_cycle_d;
            cycle_q     <= cycle_d;
            cnt_q       <= cnt_d;
            ill_q       <= ill_d;
        end
    end

    assign out_valid       = valid_q;
    assign out_class       = class_q;
    assign out_allowed     = allowed_q;
    assign illegal_seen    = seen_q;
    assign first_bad_inst  = bad_inst_q;
    assign first_bad_lane  = bad_lane_q;
    assign first_bad_cycle = bad_cycle_q;
    assign class_cnt       = cnt_q;
    assign illegal_cnt     = ill_q;

endmodule

// File: tb/tb_inst_constraint_mon.sv
// Bench for inst_constraint_mon: two configurations (full register file, and
// QED REG_LIMIT=16/MEM_RESTRICT=1 with 4-bit counters) driven in lockstep.
module tb_inst_constraint_mon;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [1:0]  inst_valid;
    logic [63:0] inst;

    always #5 clk = ~clk;

    logic [1:0]   a_out_valid, a_out_allowed, b_out_valid, b_out_allowed;
    logic [5:0]   a_out_class, b_out_class;
    logic         a_illegal_seen, b_illegal_seen;
    logic [31:0]  a_first_bad_inst, b_first_bad_inst;
    logic [1:0]   a_first_bad_lane, b_first_bad_lane;
    logic [15:0]  a_first_bad_cycle, a_illegal_cnt;
    logic [3:0]   b_first_bad_cycle, b_illegal_cnt;
    logic [127:0] a_class_cnt;
    logic [31:0]  b_class_cnt;

    inst_constraint_mon #(.LANES(2), .REG_LIMIT(32), .MEM_RESTRICT(0), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .inst_valid(inst_valid), .inst(inst),
        .out_valid(a_out_valid), .out_class(a_out_class), .out_allowed(a_out_allowed),
        .illegal_seen(a_illegal_seen), .first_bad_inst(a_first_bad_inst),
        .first_bad_lane(a_first_bad_lane), .first_bad_cycle(a_first_bad_cycle),
        .class_cnt(a_class_cnt), .illegal_cnt(a_illegal_cnt)
    );

    inst_constraint_mon #(.LANES(2), .REG_LIMIT(16), .MEM_RESTRICT(1), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .inst_valid(inst_valid), .inst(inst),
        .out_valid(b_out_valid), .out_class(b_out_class), .out_allowed(b_out_allowed),
        .illegal_seen(b_illegal_seen), .first_bad_inst(b_first_bad_inst),
        .first_bad_lane(b_first_bad_lane), .first_bad_cycle(b_first_bad_cycle),
        .class_cnt(b_class_cnt), .illegal_cnt(b_illegal_cnt)
    );

    // Uniform views of both DUTs, indexed 0 = dut_a, 1 = dut_b
    logic [1:0]  o_vld [2];
    logic [5:0]  o_cls [2];
    logic [1:0]  o_alw [2];
    logic        o_seen [2];
    logic [31:0] o_binst [2];
    logic [1:0]  o_blane [2];
    logic [15:0] o_bcyc [2];
    logic [15:0] o_ill [2];
    logic [15:0] o_cnt [2][8];

    always_comb begin
        o_vld[0] = a_out_valid;        o_vld[1] = b_out_valid;
        o_cls[0] = a_out_class;        o_cls[1] = b_out_class;
        o_alw[0] = a_out_allowed;      o_alw[1] = b_out_allowed;
        o_seen[0] = a_illegal_seen;    o_seen[1] = b_illegal_seen;
        o_binst[0] = a_first_bad_inst; o_binst[1] = b_first_bad_inst;
        o_blane[0] = a_first_bad_lane; o_blane[1] = b_first_bad_lane;
        o_bcyc[0] = a_first_bad_cycle; o_bcyc[1] = {12'd0, b_first_bad_cycle};
        o_ill[0] = a_illegal_cnt;      o_ill[1] = {12'd0, b_illegal_cnt};
        for (int c = 0; c < 8; c++) begin
            o_cnt[0][c] = a_class_cnt[c*16 +: 16];
            o_cnt[1][c] = {12'd0, b_class_cnt[c*4 +: 4]};
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]       vld;
        logic [5:0]       cls;
        logic [1:0]       alw;
        logic             seen;
        logic [31:0]      binst;
        logic [1:0]       blane;
        logic [15:0]      bcyc;
        logic [7:0][15:0] cnt;
        logic [15:0]      ill;
    } exp_t;

    exp_t sb [2][$];

    int          m_cnt [2][8];
    int          m_ill [2];
    int          m_cyc [2];
    bit          m_seen [2];
    logic [31:0] m_binst [2];
    int          m_blane [2];
    int          m_bcyc [2];
    int          cmax [2] = '{65535, 15};

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 8; c++) m_cnt[d][c] = 0;
            m_ill[d] = 0; m_cyc[d] = 0; m_seen[d] = 1'b0;
            m_binst[d] = '0; m_blane[d] = 0; m_bcyc[d] = 0;
            sb[d].delete();
        end
    endtask

    task automatic model_step(input int d, input logic [1:0] vld, input logic [5:0] cls,
                              input logic [1:0] alw, input logic clr,
                              input logic [31:0] i0, input logic [31:0] i1, output exp_t e);
        int c;
        if (clr) model_reset_one(d);
        else begin
            for (int l = 0; l < 2; l++) begin
                if (vld[l]) begin
                    if (alw[l]) begin
                        c = int'(cls[3*l +: 3]);
                        if (m_cnt[d][c] < cmax[d]) m_cnt[d][c]++;
                    end else begin
                        if (m_ill[d] < cmax[d]) m_ill[d]++;
                        if (!m_seen[d]) begin
                            m_seen[d] = 1'b1;
                            m_binst[d] = (l == 0) ? i0 : i1;
                            m_blane[d] = l;
                            m_bcyc[d] = m_cyc[d];
                        end
                    end
                end
            end
            if (m_cyc[d] < cmax[d]) m_cyc[d]++;
        end
        e.vld = vld; e.cls = cls; e.alw = alw;
        e.seen = m_seen[d]; e.binst = m_binst[d];
        e.blane = 2'(m_blane[d]); e.bcyc = 16'(m_bcyc[d]);
        for (int k = 0; k < 8; k++) e.cnt[k] = 16'(m_cnt[d][k]);
        e.ill = 16'(m_ill[d]);
    endtask

    task automatic model_reset_one(input int d);
        for (int c = 0; c < 8; c++) m_cnt[d][c] = 0;
        m_ill[d] = 0; m_cyc[d] = 0; m_seen[d] = 1'b0;
        m_binst[d] = '0; m_blane[d] = 0; m_bcyc[d] = 0;
    endtask

    task automatic check_dut(input int d, input exp_t e, input string tag);
        string p;
        p = $sformatf("%s/%s", tag, (d == 0) ? "a" : "b");
        chk({p, ".out_valid"},   32'(o_vld[d]),   32'(e.vld));
        chk({p, ".out_class"},   32'(o_cls[d]),   32'(e.cls));
        chk({p, ".out_allowed"}, 32'(o_alw[d]),   32'(e.alw));
        chk({p, ".illegal_seen"},32'(o_seen[d]),  32'(e.seen));
        chk({p, ".bad_inst"},    o_binst[d],      e.binst);
        chk({p, ".bad_lane"},    32'(o_blane[d]), 32'(e.blane));
        chk({p, ".bad_cycle"},   32'(o_bcyc[d]),  32'(e.bcyc));
        chk({p, ".illegal_cnt"}, 32'(o_ill[d]),   32'(e.ill));
        for (int c = 0; c < 8; c++)
            chk($sformatf("%s.class_cnt[%0d]", p, c), 32'(o_cnt[d][c]), 32'(e.cnt[c]));
    endtask

    task automatic check_zero(input string tag);
        exp_t z;
        z.vld = '0; z.cls = '0; z.alw = '0; z.seen = 1'b0; z.binst = '0;
        z.blane = '0; z.bcyc = '0; z.cnt = '0; z.ill = '0;
        check_dut(0, z, tag);
        check_dut(1, z, tag);
    endtask

    // One cycle: drive at negedge, push expectations, compare just after posedge
    task automatic step(input logic [1:0] vld, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [2:0] c0, input logic [2:0] c1,
                        input logic [1:0] alw_a, input logic [1:0] alw_b,
                        input logic clr, input string tag);
        exp_t e;
        logic [5:0] cls;
        @(negedge clk);
        inst_valid = vld;
        inst = {i1, i0};
        clear = clr;
        cls = {vld[1] ? c1 : 3'd0, vld[0] ? c0 : 3'd0};
        model_step(0, vld, cls, alw_a & vld, clr, i0, i1, e); sb[0].push_back(e);
        model_step(1, vld, cls, alw_b & vld, clr, i0, i1, e); sb[1].push_back(e);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            e = sb[d].pop_front();
            check_dut(d, e, tag);
        end
        $display("txn %s vld=%b inst=%08h_%08h clr=%b a:cls=%h alw=%b ill=%0d b:alw=%b ill=%0d",
                 tag, vld, i1, i0, clr, a_out_class, a_out_allowed, a_illegal_cnt,
                 b_out_allowed, b_illegal_cnt);
    endtask

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] i0;
        logic [31:0] i1;
        logic [2:0]  c0;
        logic [2:0]  c1;
        logic [1:0]  alw_a;
        logic [1:0]  alw_b;
    } vec_t;

`ifdef INST_CONSTRAINT_MUL_EN
    localparam logic [2:0] MULC = 3'd1;
    localparam logic [1:0] MULA = 2'b01;
`else
    localparam logic [2:0] MULC = 3'd0;
    localparam logic [1:0] MULA = 2'b00;
`endif

    localparam logic [31:0] NOP_W = 32'hFFFF_FFFF;

    vec_t vecs [13];

    initial begin
        #200000;
        $display("FAIL watchdog expired before the test finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'b11, 32'h00B50533, 32'h00100093, 3'd1, 3'd2, 2'b11, 2'b11};
        vecs[1]  = '{2'b01, 32'h02B50533, 32'h00000000, MULC, 3'd0, MULA,  MULA};
        vecs[2]  = '{2'b11, 32'h01F00033, 32'h00002083, 3'd1, 3'd3, 2'b11, 2'b10};
        vecs[3]  = '{2'b11, 32'h0021A023, 32'h00000063, 3'd3, 3'd4, 2'b11, 2'b10};
        vecs[4]  = '{2'b11, 32'h40B50533, 32'h0000006F, 3'd1, 3'd5, 2'b11, 2'b11};
        vecs[5]  = '{2'b11, 32'h40B55533, 32'h00008067, 3'd1, 3'd5, 2'b11, 2'b11};
        vecs[6]  = '{2'b11, 32'h40B51533, 32'h123450B7, 3'd0, 3'd6, 2'b10, 2'b10};
        vecs[7]  = '{2'b11, 32'h40155513, 32'h40151513, 3'd2, 3'd0, 2'b01, 2'b01};
        vecs[8]  = '{2'b11, 32'h00002063, NOP_W,        3'd0, 3'd7, 2'b10, 2'b10};
        vecs[9]  = '{2'b11, 32'h00500A13, 32'h00000017, 3'd2, 3'd6, 2'b11, 2'b10};
        vecs[10] = '{2'b11, 32'h80002083, 32'h00009067, 3'd3, 3'd0, 2'b01, 2'b00};
        vecs[11] = '{2'b10, 32'h00000000, 32'h00B50533, 3'd0, 3'd1, 2'b10, 2'b10};
        vecs[12] = '{2'b11, 32'h02B53533, 32'h02B54533, MULC, 3'd0, MULA,  MULA};

        reset = 1'b1; clear = 1'b0; inst_valid = '0; inst = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;

        for (int v = 0; v < 13; v++)
            step(vecs[v].vld, vecs[v].i0, vecs[v].i1, vecs[v].c0, vecs[v].c1,
                 vecs[v].alw_a, vecs[v].alw_b, 1'b0, $sformatf("vec%0d", v));

        chk("post_table.a_first_bad_inst", a_first_bad_inst,
            (MULC == 3'd0) ? 32'h02B50533 : 32'h40B51533);
        chk("post_table.b_first_bad_inst", b_first_bad_inst,
            (MULC == 3'd0) ? 32'h02B50533 : 32'h01F00033);

        // First violation at cycle counter 5, both lanes illegal
        step(2'b00, 32'h0, 32'h0, 3'd0, 3'd0, 2'b00, 2'b00, 1'b1, "clr1");
        for (int k = 0; k < 5; k++)
            step(2'b00, 32'h0, 32'h0, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, $sformatf("idle%0d", k));
        step(2'b11, 32'h0, 32'h0, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, "dual_bad");
        chk("dual.a_bad_lane",  32'(a_first_bad_lane),  32'd0);
        chk("dual.a_bad_cycle", 32'(a_first_bad_cycle), 32'd5);
        chk("dual.a_ill_cnt",   32'(a_illegal_cnt),     32'd2);
        chk("dual.b_bad_cycle", 32'(b_first_bad_cycle), 32'd5);
        step(2'b11, 32'h00B50533, 32'h00002063, 3'd1, 3'd0, 2'b01, 2'b01, 1'b0, "later_bad");
        chk("later.a_bad_lane",  32'(a_first_bad_lane),  32'd0);
        chk("later.a_bad_inst",  a_first_bad_inst,       32'h0);
        chk("later.a_bad_cycle", 32'(a_first_bad_cycle), 32'd5);

        // Counter saturation on the 4-bit instance
        step(2'b00, 32'h0, 32'h0, 3'd0, 3'd0, 2'b00, 2'b00, 1'b1, "clr2");
        for (int k = 0; k < 20; k++)
            step(2'b01, NOP_W, 32'h0, 3'd7, 3'd0, 2'b01, 2'b01, 1'b0, $sformatf("nop%0d", k));
        chk("sat.b_nop_cnt", 32'(b_class_cnt[28 +: 4]),  32'd15);
        chk("sat.a_nop_cnt", 32'(a_class_cnt[112 +: 16]), 32'd20);

        // clear beats a same-cycle violation
        step(2'b11, 32'h0, 32'h0, 3'd0, 3'd0, 2'b00, 2'b00, 1'b1, "clr_vs_bad");
        chk("clrbad.a_seen",    32'(a_illegal_seen), 32'd0);
        chk("clrbad.a_ill_cnt", 32'(a_illegal_cnt),  32'd0);
        chk("clrbad.b_seen",    32'(b_illegal_seen), 32'd0);
        chk("clrbad.a_out_vld", 32'(a_out_valid),    32'd3);

        // Build some state, then reset mid-stream with traffic on the inputs
        step(2'b11, 32'h0, 32'h00B50533, 3'd0, 3'd1, 2'b10, 2'b10, 1'b0, "pre_rst");
        @(negedge clk);
        inst_valid = 2'b11;
        inst = {32'h00100093, 32'h00000000};
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check_zero("mid_reset");
        model_reset();
        reset = 1'b0;
        step(vecs[0].vld, vecs[0].i0, vecs[0].i1, vecs[0].c0, vecs[0].c1,
             vecs[0].alw_a, vecs[0].alw_b, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_constraint_mon.md
# inst_constraint_mon

Registered, multi-lane instruction legality monitor for the RIDECORE fetch path. Each cycle it classifies up to LANES fetched instructions against the supported RV32I(+M) subset, applies the optional QED register and memory restrictions, and reports per-lane class and legality one cycle later. It also keeps saturating per-class statistics and a sticky first-violation record. The formal harness and simulation benches use it to check that generated instruction streams stay inside the supported subset.

## Interface
- LANES, 2: fetch lanes checked in parallel (1..4)
- REG_LIMIT, 32: rd/rs1/rs2 must be < REG_LIMIT; 16 gives the QED lower-half rule
- MEM_RESTRICT, 0: 1 adds the QED LW/SW rule: rs1==0 and inst[31:30]==2'b00
- CNT_W, 16: width of all counters
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- clear  in  1  synchronous; zeroes counters and the sticky record
- inst_valid  in  LANES  lane i carries an instruction this cycle
- inst  in  32*LANES  lane i occupies bits [32i+31:32i]
- out_valid  out  LANES  registered copy of inst_valid
- out_class  out  3*LANES  registered inst_class_e per lane
- out_allowed  out  LANES  registered legality; 0 on lanes that are not valid
- illegal_seen  out  1  sticky; set by the first illegal valid lane
- first_bad_inst  out  32  instruction word of the first violation
- first_bad_lane  out  2  lane of the first violation
- first_bad_cycle  out  CNT_W  cycle counter value at the first violation
- class_cnt  out  8*CNT_W  saturating count of legal instructions per class
- illegal_cnt  out  CNT_W  saturating count of illegal valid lanes

## Operation
- Class codes: NONE=0, ALU_R=1, ALU_I=2, MEM=3, BRANCH=4, JUMP=5, UPPER=6, NOP=7.
- ALU_R (opcode 0110011):
  - funct7 0000000: any funct3.
  - funct7 0100000: funct3 000 or 101.
  - funct7 0000001: funct3 000..011, and only with the macro defined.
- ALU_I (opcode 0010011):
  - funct3 000, 010, 011, 100, 110, 111: any upper bits.
  - funct3 001: funct7 0000000.
  - funct3 101: funct7 0000000 or 0100000.
- MEM: opcode 0000011 or 0100011 with funct3 010.
- BRANCH: opcode 1100011 with funct3 not 010/011.
- JUMP: opcode 1101111, or opcode 1100111 with funct3 000.
- UPPER: opcode 0110111 or 0010111.
- NOP: opcode 1111111, the fetch-stall marker.
- Any other encoding is illegal and reports class 0.
- Register limit checks:
  - R-type: rd, rs1, rs2.
  - I-type: rd, rs1.
  - LW: rd. SW: rs2.
  - Other classes are not checked.
  - A register-limit failure gives allowed=0 but keeps the decoded class.
- Cycle counter: free-running, saturating, zeroed by reset or clear.
- Statistics: each valid lane increments either its class counter or illegal_cnt. Several lanes in one cycle add their combined increment; every counter saturates at all-ones.
- First violation: captured only while illegal_seen=0. When several lanes are illegal in the same cycle, the lowest lane index wins.
- clear together with a violation in the same cycle: clear wins, and that violation is not recorded or counted.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on out_* after edge N.
- No backpressure; every cycle is accepted.
- Counters and the sticky record reflect edge N after edge N.
- Reset drives every output to 0, including all counters.
- Reset in mid-stream discards the in-flight cycle with no partial update.
- An invalid lane gives out_class=0 and out_allowed=0, and has no effect on counters.

## Configuration
- INST_CONSTRAINT_MUL_EN:
  - Defined: MUL, MULH, MULHSU, MULHU are legal ALU_R.
  - Undefined: funct7 0000001 is illegal.

## Structure
- Package inst_constraint_pkg holds:
  - inst_class_e.
  - Opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_NOP.
  - funct7 constants: F7_BASE, F7_ALT, F7_MUL.
- Sub-module inst_classify: combinational per-lane decoder with inputs inst, REG_LIMIT, MEM_RESTRICT and outputs class and allowed. It is instantiated LANES times.
- The top level holds the output registers, counters and sticky capture.

## Test plan
- Lane0 0x00B50533 (ADD), lane1 0x00100093 (ADDI) -> next cycle classes 1 and 2, allowed 2'b11, class_cnt[1]=1, class_cnt[2]=1.
- 0x02B50533 (MUL) with the macro -> class 1, allowed=1; without the macro -> class 0, allowed=0, illegal_seen=1.
- REG_LIMIT=16, 0x01F00033 (ADD x0,x0,x31) -> class 1, allowed=0, first_bad_inst=0x01F00033.
- Both lanes illegal (0x00000000) at cycle counter 5 -> first_bad_lane=0, first_bad_cycle=5, illegal_cnt=2. A later violation leaves the record unchanged.
- CNT_W=4, 20 valid NOPs on lane0 -> class_cnt[7] holds at 15.
- Assert clear in the same cycle as a violation -> illegal_seen=0 and illegal_cnt=0. Assert reset mid-stream -> all outputs 0 on the next edge.
